// File: rtl/seq_div.sv
// seq_div: iterative radix-2 restoring signed/unsigned divider with [N,Z,C,V] flags and start/busy/done handshake
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Signed,
  input  logic             S,
  input  logic [3:0]       Flag,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Rem,
  output logic [3:0]       New_Flag
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q, d, a_mag, b_mag, res, rem;
  logic [WIDTH:0] r, r_sh, diff;
  logic zero_div, min_ovf, special, sgn, s_c, neg_q, neg_r, ovf;
  logic [3:0] flag_c;
  assign Busy = state != IDLE;
  always_comb begin
    zero_div = In2 == '0;
    min_ovf = Signed && In1 == MIN && In2 == '1;
    special = zero_div || min_ovf;
    a_mag = (Signed && In1[WIDTH-1]) ? -In1 : In1;
    b_mag = (Signed && In2[WIDTH-1]) ? -In2 : In2;
    r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
    diff = r_sh - {1'b0, d};
    res = neg_q ? -q : q;
    rem = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && Start) state_n = special ? FIX : CALC;
    if (state == CALC && cnt == '0) state_n = FIX;
    if (state == FIX) state_n = IDLE;
  end
  always_ff @(posedge Clk) state <= Rst ? IDLE : state_n;
  // Special cases preload their final answer into q/r so FIX treats every op alike
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      q <= '0;
      d <= '0;
      r <= '0;
      sgn <= 1'b0;
      s_c <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf <= 1'b0;
      flag_c <= '0;
      Done <= 1'b0;
      Result <= '0;
      Rem <= '0;
      New_Flag <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          s_c <= S;
          flag_c <= Flag;
          sgn <= Signed;
          cnt <= CW'(WIDTH-1);
          d <= b_mag;
          q <= zero_div ? '1 : min_ovf ? MIN : a_mag;
          r <= zero_div ? {1'b0, In1} : '0;
          neg_q <= !special && Signed && (In1[WIDTH-1] ^ In2[WIDTH-1]);
          neg_r <= !special && Signed && In1[WIDTH-1];
          ovf <= special;
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          r <= diff[WIDTH] ? r_sh : diff;
          q <= {q[WIDTH-2:0], !diff[WIDTH]};
        end
        FIX: begin
          Result <= res;
          Rem <= rem;
          New_Flag <= s_c ? {sgn & res[WIDTH-1], res == '0, rem != '0, ovf} : flag_c;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
